// File: rtl/card_slot_renderer.sv
// Card-row renderer: hit-tests the VGA pixel against a row of card slots, fetches
// sprite pixels from an external synchronous ROM and emits RGB444 three cycles later.
module card_slot_renderer #(
  parameter int          N_SLOTS      = 7,
  parameter int          X0           = 80,
  parameter int          Y0           = 360,
  parameter int          SLOT_PITCH   = 48,
  parameter int          CARD_W       = 40,
  parameter int          CARD_H       = 56,
  parameter int          ROM_AW       = 17,
  parameter logic [11:0] BG_COLOR     = 12'h061,
  parameter logic [11:0] BORDER_COLOR = 12'hFFF,
  parameter logic [11:0] HL_COLOR     = 12'hFF0,
  parameter logic [11:0] TRANSPARENT  = 12'hF0F
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              vde_in,
  input  logic [9:0]        drawX,
  input  logic [9:0]        drawY,
  input  logic              card_we,
  input  logic [2:0]        card_slot,
  input  logic [7:0]        card_code,
  input  logic              sel_en,
  input  logic [2:0]        sel_slot,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hs_out,
  output logic              vs_out,
  output logic              vde_out
);
  localparam int                 LXW         = $clog2(CARD_W);
  localparam int                 LYW         = $clog2(CARD_H);
  localparam logic [3:0]         N_SLOTS_L   = 4'(N_SLOTS);
  localparam logic signed [11:0] Y0_S        = 12'(Y0);
  localparam logic signed [11:0] CW_S        = 12'(CARD_W);
  localparam logic signed [11:0] CH_S        = 12'(CARD_H);
  localparam logic [LXW-1:0]     LX_LAST     = LXW'(CARD_W - 1);
  localparam logic [LYW-1:0]     LY_LAST     = LYW'(CARD_H - 1);
  localparam logic [ROM_AW-1:0]  SPRITE_SIZE = ROM_AW'(CARD_W * CARD_H);
  localparam logic [ROM_AW-1:0]  ROW_STRIDE  = ROM_AW'(CARD_W);

  function automatic logic [11:0] pick_color(input logic vld, input logic hit, input logic ok,
                                             input logic border, input logic hl,
                                             input logic [11:0] rom);
    if (!vld)               return 12'h000;
    if (!hit || !ok)        return BG_COLOR;
    if (border)             return hl ? HL_COLOR : BORDER_COLOR;
    if (rom == TRANSPARENT) return BG_COLOR;
    return rom;
  endfunction

  // Card tables: game logic writes the shadow copy, the renderer only reads the active copy
  logic [7:0] shadow [N_SLOTS];
  logic [7:0] active [N_SLOTS];
  logic       vs_prev;
  logic       vs_fall;

  assign vs_fall = vs_prev & ~vs_in;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      vs_prev <= 1'b1;
      shadow  <= '{default: '0};
      active  <= '{default: '0};
    end else begin
      vs_prev <= vs_in;
      if (vs_fall) active <= shadow;
      if (card_we && ({1'b0, card_slot} < N_SLOTS_L)) shadow[card_slot] <= card_code;
    end
  end

  logic signed [11:0] dx_c;
  logic signed [11:0] dy_c;
  logic               hit_c, card_ok_c, border_c, hl_c;
  logic [2:0]         slot_c;
  logic [LXW-1:0]     lx_c;
  logic [LYW-1:0]     ly_c;
  logic [7:0]         code_c;
  logic [6:0]         sid_c;
  logic [ROM_AW-1:0]  addr_c;

  always_comb begin
    dx_c   = '0;
    hit_c  = 1'b0;
    slot_c = '0;
    lx_c   = '0;
    dy_c   = $signed({2'b00, drawY}) - Y0_S;
    for (int i = 0; i < N_SLOTS; i++) begin
      dx_c = $signed({2'b00, drawX}) - $signed(12'(X0 + i * SLOT_PITCH));
      if (dx_c >= 12'sd0 && dx_c < CW_S && dy_c >= 12'sd0 && dy_c < CH_S) begin
        hit_c  = 1'b1;
        slot_c = 3'(i);
        lx_c   = dx_c[LXW-1:0];
      end
    end
    ly_c      = dy_c[LYW-1:0];
    code_c    = active[slot_c];
    card_ok_c = code_c[7] && (code_c[3:0] != 4'd0) && (code_c[3:0] <= 4'd13);
    // Sprite 52 is the shared card back
    sid_c     = code_c[6] ? (7'(code_c[5:4]) * 7'd13 + 7'(code_c[3:0]) - 7'd1) : 7'd52;
    addr_c    = ROM_AW'(sid_c) * SPRITE_SIZE + ROM_AW'(ly_c) * ROW_STRIDE + ROM_AW'(lx_c);
    border_c  = (lx_c == '0) || (lx_c == LX_LAST) || (ly_c == '0) || (ly_c == LY_LAST);
    hl_c      = sel_en && (sel_slot == slot_c);
  end

  // S1: hit test registered, ROM address issued
  logic hit_p1, card_ok_p1, border_p1, hl_p1, vld_p1, hs_p1, vs_p1;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      rom_addr   <= '0;
      hit_p1     <= 1'b0;
      card_ok_p1 <= 1'b0;
      border_p1  <= 1'b0;
      hl_p1      <= 1'b0;
      vld_p1     <= 1'b0;
      hs_p1      <= 1'b1;
      vs_p1      <= 1'b1;
    end else begin
      rom_addr   <= hit_c ? addr_c : '0;
      hit_p1     <= hit_c;
      card_ok_p1 <= card_ok_c;
      border_p1  <= border_c;
      hl_p1      <= hl_c;
      vld_p1     <= vde_in;
      hs_p1      <= hs_in;
      vs_p1      <= vs_in;
    end
  end

  // S2: flags wait alongside the ROM read
  logic hit_p2, card_ok_p2, border_p2, hl_p2, vld_p2, hs_p2, vs_p2;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      hit_p2     <= 1'b0;
      card_ok_p2 <= 1'b0;
      border_p2  <= 1'b0;
      hl_p2      <= 1'b0;
      vld_p2     <= 1'b0;
      hs_p2      <= 1'b1;
      vs_p2      <= 1'b1;
    end else begin
      hit_p2     <= hit_p1;
      card_ok_p2 <= card_ok_p1;
      border_p2  <= border_p1;
      hl_p2      <= hl_p1;
      vld_p2     <= vld_p1;
      hs_p2      <= hs_p1;
      vs_p2      <= vs_p1;
    end
  end

  // S3: colour selection into the output register
  logic [11:0] color_p2;

  assign color_p2 = pick_color(vld_p2, hit_p2, card_ok_p2, border_p2, hl_p2, rom_data);

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      {red, green, blue} <= 12'h000;
      hs_out             <= 1'b1;
      vs_out             <= 1'b1;
      vde_out            <= 1'b0;
    end else begin
      {red, green, blue} <= color_p2;
      hs_out             <= hs_p2;
      vs_out             <= vs_p2;
      vde_out            <= vld_p2;
    end
  end

endmodule

// File: tb/tb_card_slot_renderer.sv
// Bench for card_slot_renderer: behavioural frame/table model checked every cycle,
// plus directed probes with hand-computed pixel and address values.
module tb_card_slot_renderer;
  localparam logic [11:0] BG     = 12'h061;
  localparam logic [11:0] BORDER = 12'hFFF;
  localparam logic [11:0] HL     = 12'hFF0;
  localparam logic [11:0] TRANSP = 12'hF0F;

  logic        pixel_clk = 1'b0;
  logic        reset     = 1'b1;
  logic        hs_in     = 1'b1;
  logic        vs_in     = 1'b1;
  logic        vde_in    = 1'b0;
  logic [9:0]  drawX     = '0;
  logic [9:0]  drawY     = '0;
  logic        card_we   = 1'b0;
  logic [2:0]  card_slot = '0;
  logic [7:0]  card_code = '0;
  logic        sel_en    = 1'b0;
  logic [2:0]  sel_slot  = '0;
  logic [16:0] rom_addr;
  logic [11:0] rom_data;
  logic [3:0]  red, green, blue;
  logic        hs_out, vs_out, vde_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 pixel_clk = ~pixel_clk;

  card_slot_renderer dut (
    .pixel_clk(pixel_clk), .reset(reset), .hs_in(hs_in), .vs_in(vs_in), .vde_in(vde_in),
    .drawX(drawX), .drawY(drawY), .card_we(card_we), .card_slot(card_slot),
    .card_code(card_code), .sel_en(sel_en), .sel_slot(sel_slot), .rom_addr(rom_addr),
    .rom_data(rom_data), .red(red), .green(green), .blue(blue),
    .hs_out(hs_out), .vs_out(vs_out), .vde_out(vde_out)
  );

  // Sprite ROM contents: address-derived words, colour key only at address 820
  function automatic logic [11:0] rom_word(input logic [16:0] a);
    logic [11:0] w;
    if (a == 17'd820) return TRANSP;
    w = a[11:0] ^ {a[16:12], 7'h35};
    if (w == TRANSP) w = 12'h0F0;
    return w;
  endfunction

  always @(posedge pixel_clk) rom_data <= rom_word(rom_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Model state
  logic [7:0]  m_shadow [7];
  logic [7:0]  m_active [7];
  logic        m_vs_prev = 1'b1;
  logic [11:0] h_pix [4];
  logic        h_hs  [4];
  logic        h_vs  [4];
  logic        h_vde [4];
  logic        h_rst [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  logic [11:0] x_rgb;
  logic        x_hs, x_vs, x_vde, x_addr_chk;
  logic [16:0] x_addr;
  int          cyc = 0;

  task automatic model_pixel(input int x, input int y, input logic vde, input logic se,
                             input logic [2:0] ss, output logic [11:0] pix,
                             output logic [16:0] addr, output logic addr_chk);
    int lx, ly, rank, id;
    logic [7:0]  code;
    logic [11:0] w;
    pix = BG; addr = '0; addr_chk = 1'b1;
    for (int s = 0; s < 7; s++) begin
      if (x >= 80 + 48 * s && x < 120 + 48 * s && y >= 360 && y < 416) begin
        lx   = x - (80 + 48 * s);
        ly   = y - 360;
        code = m_active[s];
        rank = int'(code[3:0]);
        id   = code[6] ? int'(code[5:4]) * 13 + rank - 1 : 52;
        addr = 17'(id * 2240 + ly * 40 + lx);
        addr_chk = code[7] && rank >= 1 && rank <= 13;
        if (addr_chk) begin
          w = rom_word(addr);
          if (lx == 0 || lx == 39 || ly == 0 || ly == 55)
            pix = (se && ss == 3'(s)) ? HL : BORDER;
          else
            pix = (w == TRANSP) ? BG : w;
        end
      end
    end
    if (!vde) pix = 12'h000;
  endtask

  initial begin
    logic [11:0] p;
    logic [16:0] a;
    logic        ac;
    int          k0, k1, k2;
    forever begin
      @(posedge pixel_clk);
      k0 = cyc % 4; k1 = (cyc + 3) % 4; k2 = (cyc + 2) % 4;
      model_pixel(int'(drawX), int'(drawY), vde_in, sel_en, sel_slot, p, a, ac);
      h_pix[k0] = p; h_hs[k0] = hs_in; h_vs[k0] = vs_in; h_vde[k0] = vde_in; h_rst[k0] = reset;
      if (reset || h_rst[k1] || h_rst[k2]) begin
        x_rgb = 12'h000; x_hs = 1'b1; x_vs = 1'b1; x_vde = 1'b0;
      end else begin
        x_rgb = h_pix[k2]; x_hs = h_hs[k2]; x_vs = h_vs[k2]; x_vde = h_vde[k2];
      end
      x_addr     = reset ? 17'd0 : a;
      x_addr_chk = reset | ac;
      if (reset) begin
        for (int s = 0; s < 7; s++) begin m_shadow[s] = '0; m_active[s] = '0; end
        m_vs_prev = 1'b1;
      end else begin
        if (m_vs_prev && !vs_in) m_active = m_shadow;
        if (card_we && card_slot < 3'd7) m_shadow[card_slot] = card_code;
        m_vs_prev = vs_in;
      end
      cyc++;
    end
  end

  // Compare process
  initial begin
    forever begin
      @(negedge pixel_clk);
      if (cyc >= 3) begin
        chk("rgb", 32'({red, green, blue}), 32'(x_rgb));
        chk("hs_out", 32'(hs_out), 32'(x_hs));
        chk("vs_out", 32'(vs_out), 32'(x_vs));
        chk("vde_out", 32'(vde_out), 32'(x_vde));
        if (x_addr_chk) chk("rom_addr", 32'(rom_addr), 32'(x_addr));
      end
    end
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic write_card(input logic [2:0] s, input logic [7:0] c);
    card_we = 1'b1; card_slot = s; card_code = c;
    tick();
    card_we = 1'b0;
  endtask

  task automatic vsync();
    vs_in = 1'b0; vde_in = 1'b0;
    tick(); tick();
    vs_in = 1'b1;
    tick();
  endtask

  task automatic probe(input int x, input int y, input logic [11:0] exp_rgb, input string nm,
                       input logic chk_a, input logic [16:0] exp_a);
    drawX = 10'(x); drawY = 10'(y); vde_in = 1'b1;
    tick();
    if (chk_a) chk({nm, "_addr"}, 32'(rom_addr), 32'(exp_a));
    tick(); tick();
    chk(nm, 32'({red, green, blue}), 32'(exp_rgb));
  endtask

  task automatic scan(input int y);
    for (int x = 60; x < 430; x++) begin
      drawX = 10'(x); drawY = 10'(y); vde_in = (x < 420); hs_in = (x % 32) >= 4;
      tick();
    end
    hs_in = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_rgb"}, 32'({red, green, blue}), 32'h000);
    chk({nm, "_hs"}, 32'(hs_out), 32'h1);
    chk({nm, "_vs"}, 32'(vs_out), 32'h1);
    chk({nm, "_vde"}, 32'(vde_out), 32'h0);
    chk({nm, "_addr"}, 32'(rom_addr), 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) tick();
    chk_reset_outputs("reset");
    reset = 1'b0;

    scan(370);
    probe(85, 370, BG, "blank_frame", 1'b0, 17'd0);

    write_card(3'd0, 8'hC1);
    vsync();
    probe(85, 370, 12'h1A0, "ace_pixel", 1'b1, 17'd405);

    write_card(3'd2, 8'h85);
    probe(177, 361, BG, "midframe_hold", 1'b0, 17'd0);
    vsync();
    probe(177, 361, 12'h91C, "card_back", 1'b1, 17'd116521);

    sel_en = 1'b1; sel_slot = 3'd2;
    probe(176, 360, HL, "hl_border", 1'b0, 17'd0);
    probe(80, 360, BORDER, "border", 1'b0, 17'd0);
    scan(360);
    scan(415);

    write_card(3'd7, 8'hC5);
    write_card(3'd3, 8'hC0);
    write_card(3'd4, 8'hCE);
    write_card(3'd5, 8'h41);
    vsync();
    probe(229, 370, BG, "rank0", 1'b0, 17'd0);
    probe(277, 370, BG, "rank14", 1'b0, 17'd0);
    probe(325, 370, BG, "not_valid", 1'b0, 17'd0);
    probe(100, 380, BG, "transparent", 1'b1, 17'd820);
    scan(380);

    vs_in = 1'b0; vde_in = 1'b0;
    card_we = 1'b1; card_slot = 3'd1; card_code = 8'hD2;
    tick();
    card_we = 1'b0;
    tick();
    vs_in = 1'b1;
    tick();
    probe(133, 370, BG, "commit_race_old", 1'b0, 17'd0);
    vsync();
    probe(133, 370, 12'hFA0, "commit_race_new", 1'b1, 17'd31765);
    sel_en = 1'b0;
    scan(370);

    drawX = 10'd130; drawY = 10'd370; vde_in = 1'b1; hs_in = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk_reset_outputs("midline_reset");
    reset = 1'b0; hs_in = 1'b1;
    probe(133, 370, BG, "after_reset", 1'b0, 17'd0);
    scan(370);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
